// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icode encodings, PC-unit state type, default address width.
package y86_pkg;

    localparam int unsigned ADDR_W_DEF = 64;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_ERROR = 2'd2
    } pc_state_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; when full a push silently overwrites the oldest entry.
module ras_stack #(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned RAS_DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_data,
    output logic [ADDR_W-1:0] o_top,
    output logic              o_empty
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_top;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_wr_idx;
    logic              w_full;
    logic              w_do_pop;

    assign w_wr_idx = r_top + 1'b1;
    assign w_full   = (r_count == CNT_W'(RAS_DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_top    = o_empty ? '0 : r_mem[r_top];
    assign w_do_pop = i_pop & ~i_push & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_top   <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_top <= w_wr_idx;
            if (!w_full)
                r_count <= r_count + 1'b1;
        end else if (w_do_pop) begin
            r_top   <= r_top - 1'b1;
            r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && i_push)
            r_mem[w_wr_idx] <= i_data;
    end

endmodule

// File: rtl/pc_unit_ras.sv
// Y86-64 PC update register with RUN/HALT/ERROR FSM and return-address prediction.
// Define PC_UNIT_PERF_EN to add retired/taken/RAS-miss performance counters.
module pc_unit_ras
    import y86_pkg::*;
#(
    parameter int unsigned     ADDR_W    = ADDR_W_DEF,
    parameter int unsigned     RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_stall,
    input  logic [3:0]        i_icode,
    input  logic              i_cnd,
    input  logic [ADDR_W-1:0] i_valC,
    input  logic [ADDR_W-1:0] i_valM,
    input  logic [ADDR_W-1:0] i_valP,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_halted,
    output logic              o_error,
    output logic [ADDR_W-1:0] o_ras_pred,
    output logic              o_ras_empty,
`ifdef PC_UNIT_PERF_EN
    output logic [31:0]       o_retired_cnt,
    output logic [31:0]       o_taken_cnt,
    output logic [15:0]       o_miss_cnt,
`endif
    output logic              o_ras_miss
);

    pc_state_t         r_state;
    pc_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              r_miss;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_taken;
    logic              w_miss_nxt;

    assign w_accept = i_valid & ~i_stall & (r_state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_pc    <= RESET_PC;
            r_miss  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_miss  <= w_miss_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_taken     = 1'b0;
        if (w_accept) begin
            case (i_icode)
                I_HALT: begin
                    w_pc_nxt    = i_valP;
                    w_state_nxt = ST_HALT;
                end
                I_NOP, I_RRMOVQ, I_IRMOVQ, I_RMMOVQ,
                I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ:
                    w_pc_nxt = i_valP;
                I_JXX: begin
                    w_pc_nxt = i_cnd ? i_valC : i_valP;
                    w_taken  = i_cnd;
                end
                I_CALL: begin
                    w_pc_nxt = i_valC;
                    w_push   = 1'b1;
                    w_taken  = 1'b1;
                end
                I_RET: begin
                    w_pc_nxt = i_valM;
                    w_pop    = 1'b1;
                end
                default: w_state_nxt = ST_ERROR;
            endcase
        end
    end

    // Prediction is checked against the entry before the pop takes effect.
    assign w_miss_nxt = w_pop & ~o_ras_empty & (o_ras_pred != i_valM);

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (i_valP),
        .o_top   (o_ras_pred),
        .o_empty (o_ras_empty)
    );

`ifdef PC_UNIT_PERF_EN
    logic [31:0] r_retired_cnt;
    logic [31:0] r_taken_cnt;
    logic [15:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_retired_cnt <= '0;
            r_taken_cnt   <= '0;
            r_miss_cnt    <= '0;
        end else begin
            if (w_accept)   r_retired_cnt <= r_retired_cnt + 1'b1;
            if (w_taken)    r_taken_cnt   <= r_taken_cnt + 1'b1;
            if (w_miss_nxt) r_miss_cnt    <= r_miss_cnt + 1'b1;
        end
    end

    assign o_retired_cnt = r_retired_cnt;
    assign o_taken_cnt   = r_taken_cnt;
    assign o_miss_cnt    = r_miss_cnt;
`endif

    assign o_pc       = r_pc;
    assign o_halted   = (r_state == ST_HALT);
    assign o_error    = (r_state == ST_ERROR);
    assign o_ras_miss = r_miss;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed self-checking bench for pc_unit_ras (default parameters, RAS_DEPTH=8).
module tb_pc_unit_ras;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_stall;
    logic [3:0]  i_icode;
    logic        i_cnd;
    logic [63:0] i_valC;
    logic [63:0] i_valM;
    logic [63:0] i_valP;
    logic [63:0] o_pc;
    logic        o_halted;
    logic        o_error;
    logic [63:0] o_ras_pred;
    logic        o_ras_empty;
    logic        o_ras_miss;
`ifdef PC_UNIT_PERF_EN
    logic [31:0] o_retired_cnt;
    logic [31:0] o_taken_cnt;
    logic [15:0] o_miss_cnt;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;

    pc_unit_ras #(
        .ADDR_W    (64),
        .RAS_DEPTH (8),
        .RESET_PC  (64'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_stall     (i_stall),
        .i_icode     (i_icode),
        .i_cnd       (i_cnd),
        .i_valC      (i_valC),
        .i_valM      (i_valM),
        .i_valP      (i_valP),
        .o_pc        (o_pc),
        .o_halted    (o_halted),
        .o_error     (o_error),
        .o_ras_pred  (o_ras_pred),
        .o_ras_empty (o_ras_empty),
`ifdef PC_UNIT_PERF_EN
        .o_retired_cnt (o_retired_cnt),
        .o_taken_cnt   (o_taken_cnt),
        .o_miss_cnt    (o_miss_cnt),
`endif
        .o_ras_miss  (o_ras_miss)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, then sample #1 after the edge.
    task automatic step(input logic v, input logic s, input logic [3:0] ic, input logic c,
                        input logic [63:0] vc, input logic [63:0] vm, input logic [63:0] vp);
        i_valid = v; i_stall = s; i_icode = ic; i_cnd = c;
        i_valC = vc; i_valM = vm; i_valP = vp;
        @(posedge clk);
        #1;
        i_valid = 1'b0; i_stall = 1'b0;
    endtask

    task automatic do_reset(input logic v, input logic s, input logic [3:0] ic);
        rst = 1'b1;
        step(v, s, ic, 1'b0, 64'h500, 64'h600, 64'h700);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; i_valid = 1'b0; i_stall = 1'b0; i_icode = 4'h1; i_cnd = 1'b0;
        i_valC = '0; i_valM = '0; i_valP = '0;
        #2;
        do_reset(1'b0, 1'b0, 4'h1);
        chk("rst_pc",     o_pc, 64'h0);
        chk("rst_halted", {63'b0, o_halted}, 64'h0);
        chk("rst_error",  {63'b0, o_error}, 64'h0);
        chk("rst_empty",  {63'b0, o_ras_empty}, 64'h1);
        chk("rst_pred",   o_ras_pred, 64'h0);
        chk("rst_miss",   {63'b0, o_ras_miss}, 64'h0);

        step(1'b1, 1'b1, 4'h3, 1'b0, 64'h0, 64'h0, 64'h0A);
        chk("stall_hold", o_pc, 64'h0);
        step(1'b1, 1'b0, 4'h3, 1'b0, 64'h0, 64'h0, 64'h0A);
        chk("irmovq", o_pc, 64'h0A);

        step(1'b1, 1'b0, 4'h7, 1'b1, 64'h100, 64'h0, 64'h20);
        chk("jxx_taken", o_pc, 64'h100);
        step(1'b1, 1'b0, 4'h7, 1'b0, 64'h100, 64'h0, 64'h20);
        chk("jxx_not_taken", o_pc, 64'h20);

        step(1'b1, 1'b0, 4'h8, 1'b0, 64'h200, 64'h0, 64'h30);
        chk("call_pc",    o_pc, 64'h200);
        chk("call_pred",  o_ras_pred, 64'h30);
        chk("call_empty", {63'b0, o_ras_empty}, 64'h0);
        step(1'b1, 1'b0, 4'h9, 1'b0, 64'h0, 64'h30, 64'h0);
        chk("ret_hit_pc",    o_pc, 64'h30);
        chk("ret_hit_miss",  {63'b0, o_ras_miss}, 64'h0);
        chk("ret_hit_empty", {63'b0, o_ras_empty}, 64'h1);

        step(1'b1, 1'b0, 4'h8, 1'b0, 64'h200, 64'h0, 64'h30);
        step(1'b1, 1'b0, 4'h9, 1'b0, 64'h0, 64'h99, 64'h0);
        chk("ret_miss_pc",    o_pc, 64'h99);
        chk("ret_miss_pulse", {63'b0, o_ras_miss}, 64'h1);
        step(1'b0, 1'b0, 4'h1, 1'b0, 64'h0, 64'h0, 64'h0);
        chk("miss_one_cycle", {63'b0, o_ras_miss}, 64'h0);
        chk("idle_pc", o_pc, 64'h99);

        for (int i = 1; i <= 9; i++)
            step(1'b1, 1'b0, 4'h8, 1'b0, 64'h300, 64'h0, 64'(i));
        chk("wrap_top",   o_ras_pred, 64'h9);
        chk("wrap_empty", {63'b0, o_ras_empty}, 64'h0);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("pop_pred_%0d", k), o_ras_pred, 64'(9 - k));
            step(1'b1, 1'b0, 4'h9, 1'b0, 64'h0, 64'(9 - k), 64'h0);
            chk($sformatf("pop_miss_%0d", k), {63'b0, o_ras_miss}, 64'h0);
        end
        chk("drained_empty", {63'b0, o_ras_empty}, 64'h1);
        chk("drained_pred",  o_ras_pred, 64'h0);
        step(1'b1, 1'b0, 4'h9, 1'b0, 64'h0, 64'h123, 64'h0);
        chk("empty_ret_miss", {63'b0, o_ras_miss}, 64'h0);
        chk("empty_ret_pc",   o_pc, 64'h123);
`ifdef PC_UNIT_PERF_EN
        chk("perf_retired", {32'b0, o_retired_cnt}, 64'd25);
        chk("perf_taken",   {32'b0, o_taken_cnt}, 64'd12);
        chk("perf_miss",    {48'b0, o_miss_cnt}, 64'd1);
`endif

        step(1'b1, 1'b0, 4'h0, 1'b0, 64'h0, 64'h0, 64'h44);
        chk("halt_pc",     o_pc, 64'h44);
        chk("halt_flag",   {63'b0, o_halted}, 64'h1);
        step(1'b1, 1'b0, 4'h1, 1'b0, 64'h0, 64'h0, 64'h50);
        chk("halt_sticky", o_pc, 64'h44);

        do_reset(1'b1, 1'b1, 4'h8);
        chk("rerst_pc",     o_pc, 64'h0);
        chk("rerst_halted", {63'b0, o_halted}, 64'h0);
        chk("rerst_empty",  {63'b0, o_ras_empty}, 64'h1);

        step(1'b1, 1'b0, 4'h1, 1'b0, 64'h0, 64'h0, 64'h10);
        chk("nop_pc", o_pc, 64'h10);
        step(1'b1, 1'b1, 4'h1, 1'b0, 64'h0, 64'h0, 64'h20);
        step(1'b1, 1'b0, 4'hE, 1'b0, 64'h0, 64'h0, 64'h77);
        chk("err_pc",   o_pc, 64'h10);
        chk("err_flag", {63'b0, o_error}, 64'h1);
        step(1'b1, 1'b0, 4'h1, 1'b0, 64'h0, 64'h0, 64'h80);
        chk("err_sticky_pc",  o_pc, 64'h10);
        chk("err_sticky_flag", {63'b0, o_error}, 64'h1);
        chk("err_not_halted", {63'b0, o_halted}, 64'h0);
`ifdef PC_UNIT_PERF_EN
        chk("perf_retired_err", {32'b0, o_retired_cnt}, 64'd2);
        chk("perf_taken_err",   {32'b0, o_taken_cnt}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
